// File: rtl/ram_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_master_pkg
//  Brief    : Shared types and defaults for the RAM burst master.
//             Optional statistics are enabled with RAM_MASTER_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_master_pkg;

  localparam int unsigned DEF_AW     = 12;
  localparam int unsigned DEF_DW     = 8;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned DEF_RD_LAT = 1;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD       = 2'd2,
    ST_RD_DRAIN = 2'd3
  } state_t;

  // Saturating increment for the beat statistics counters
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_track.sv
`default_nettype none
// ============================================================================
//  Module   : rd_track
//  Brief    : Delays the {valid,last} tag of each RAM read issue by RD_LAT
//             cycles so it lines up with the RAM read data.
//  Revision : 1.0 - initial release
// ============================================================================
module rd_track #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  generate
    if (RD_LAT == 0) begin : g_pass
      // Combinational RAM: the tag is already aligned with the data
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign o_valid = i_valid;
      assign o_last  = i_last;
    end else begin : g_pipe
      logic [RD_LAT-1:0] r_valid;
      logic [RD_LAT-1:0] r_last;

      // Shift the tag one stage per cycle; reset drops in-flight beats
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= '0;
          r_last  <= '0;
        end else begin
          r_valid[0] <= i_valid;
          r_last[0]  <= i_last;
          for (int i = 1; i < RD_LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_last[i]  <= r_last[i-1];
          end
        end
      end

      assign o_valid = r_valid[RD_LAT-1];
      assign o_last  = r_last[RD_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : ram_burst_master
//  Brief    : Burst initiator for a synchronous single-port RAM. Accepts
//             read/write bursts of 1..2**LEN_W beats, streams write beats in
//             and read beats out, and owns all RAM address/enable sequencing.
//             Define RAM_MASTER_STATS_EN to add saturating beat counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_burst_master
  import ram_master_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [AW-1:0]     i_req_addr,
  input  logic [LEN_W-1:0]  i_req_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DW-1:0]     i_wdata,
  output logic              o_rdata_valid,
  output logic [DW-1:0]     o_rdata,
  output logic              o_rdata_last,
  output logic              o_done,
  output logic              o_busy,
  output logic [AW-1:0]     o_ram_addr,
  output logic [DW-1:0]     o_ram_din,
  output logic              o_ram_wr_en,
  input  logic [DW-1:0]     i_ram_dout
`ifdef RAM_MASTER_STATS_EN
  ,
  output logic [STAT_W-1:0] o_wr_beats,
  output logic [STAT_W-1:0] o_rd_beats
`endif
);

  state_t            r_state;
  logic [AW-1:0]     r_cur_addr;
  logic [AW-1:0]     r_addr_hold;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic              r_wr_done;

  logic              w_in_wr;
  logic              w_in_rd;
  logic              w_wr_beat;
  logic              w_last_cnt;
  logic              w_issue_last;
  logic              w_trk_valid;
  logic              w_trk_last;

  assign w_in_wr      = (r_state == ST_WR);
  assign w_in_rd      = (r_state == ST_RD);
  assign w_wr_beat    = w_in_wr & i_wdata_valid;
  assign w_last_cnt   = (r_beat_cnt == '0);
  assign w_issue_last = w_in_rd & w_last_cnt;

  // Burst sequencing: accept a command, walk the address, count beats down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_beat_cnt <= '0;
      r_wr_done  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_cur_addr <= i_req_addr;
            r_beat_cnt <= i_req_len;
            r_state    <= i_req_we ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          // A missing write beat simply stalls; nothing moves
          if (i_wdata_valid) begin
            r_cur_addr <= r_cur_addr + 1'b1;
            if (w_last_cnt) begin
              r_state   <= ST_IDLE;
              r_wr_done <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt - 1'b1;
            end
          end
        end
        ST_RD: begin
          r_cur_addr <= r_cur_addr + 1'b1;
          if (w_last_cnt) begin
            // With a registered RAM the final beat is still in flight
            r_state <= (RD_LAT != 0) ? ST_RD_DRAIN : ST_IDLE;
          end else begin
            r_beat_cnt <= r_beat_cnt - 1'b1;
          end
        end
        ST_RD_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Remember the last address put on the RAM so it holds while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hold <= '0;
    end else if (w_in_wr | w_in_rd) begin
      r_addr_hold <= r_cur_addr;
    end
  end

  rd_track #(
    .RD_LAT (RD_LAT)
  ) u_rd_track (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_in_rd),
    .i_last  (w_issue_last),
    .o_valid (w_trk_valid),
    .o_last  (w_trk_last)
  );

  assign o_req_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_wdata_ready = w_in_wr;

  assign o_ram_wr_en   = w_wr_beat;
  assign o_ram_din     = w_wr_beat ? i_wdata : '0;
  assign o_ram_addr    = (w_in_wr | w_in_rd) ? r_cur_addr : r_addr_hold;

  // Read data is gated by the tag so it reads zero between beats
  assign o_rdata_valid = w_trk_valid;
  assign o_rdata       = w_trk_valid ? i_ram_dout : '0;
  assign o_rdata_last  = w_trk_valid & w_trk_last;

  // Writes finish a cycle after the last beat; reads finish with the last beat
  assign o_done        = r_wr_done | (w_trk_valid & w_trk_last);

`ifdef RAM_MASTER_STATS_EN
  logic [STAT_W-1:0] r_wr_beats;
  logic [STAT_W-1:0] r_rd_beats;

  // Count accepted write beats and delivered read beats, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_beats <= '0;
      r_rd_beats <= '0;
    end else begin
      if (w_wr_beat) begin
        r_wr_beats <= sat_inc(r_wr_beats);
      end
      if (w_trk_valid) begin
        r_rd_beats <= sat_inc(r_rd_beats);
      end
    end
  end

  assign o_wr_beats = r_wr_beats;
  assign o_rd_beats = r_rd_beats;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_burst_master
//  Brief    : Self-checking bench for ram_burst_master with an attached RAM
//             model and an address-arithmetic reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_master;
  import ram_master_pkg::*;

  localparam int AW     = 12;
  localparam int DW     = 8;
  localparam int LEN_W  = 4;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              wdata_valid = 1'b0;
  logic              wdata_ready;
  logic [DW-1:0]     wdata = '0;
  logic              rdata_valid;
  logic [DW-1:0]     rdata;
  logic              rdata_last;
  logic              done;
  logic              busy;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic              ram_wr_en;
  logic [DW-1:0]     ram_dout = '0;
`ifdef RAM_MASTER_STATS_EN
  logic [STAT_W-1:0] wr_beats;
  logic [STAT_W-1:0] rd_beats;
`endif

  always #5 clk = ~clk;

  ram_burst_master #(
    .AW(AW), .DW(DW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_we      (req_we),
    .i_req_addr    (req_addr),
    .i_req_len     (req_len),
    .i_wdata_valid (wdata_valid),
    .o_wdata_ready (wdata_ready),
    .i_wdata       (wdata),
    .o_rdata_valid (rdata_valid),
    .o_rdata       (rdata),
    .o_rdata_last  (rdata_last),
    .o_done        (done),
    .o_busy        (busy),
    .o_ram_addr    (ram_addr),
    .o_ram_din     (ram_din),
    .o_ram_wr_en   (ram_wr_en),
    .i_ram_dout    (ram_dout)
`ifdef RAM_MASTER_STATS_EN
    ,
    .o_wr_beats    (wr_beats),
    .o_rd_beats    (rd_beats)
`endif
  );

  // Synchronous single-port RAM with one cycle of read latency
  logic [DW-1:0] ram_mem [DEPTH];
  logic          mem_clear = 1'b1;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
    end else if (ram_wr_en) begin
      ram_mem[ram_addr] <= ram_din;
    end
    ram_dout <= ram_mem[ram_addr];
  end

  // Reference contents: what the bench believes it has written
  logic [DW-1:0] ref_mem [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { int cyc; logic [DW-1:0] d; logic last; } rd_t;
  wr_t wr_log [$];
  rd_t rd_log [$];
  int  done_log [$];
  int  acc_log [$];

  // Observation of RAM writes, read beats, done pulses and acceptances
  always @(negedge clk) begin
    if (ram_wr_en)              wr_log.push_back('{cyc, ram_addr, ram_din});
    if (rdata_valid)            rd_log.push_back('{cyc, rdata, rdata_last});
    if (done)                   done_log.push_back(cyc);
    if (req_valid && req_ready) acc_log.push_back(cyc);
  end

  int vectors = 0;
  int miscompares = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input int i);
    return AW'(int'(a) + i);
  endfunction

  task automatic send_req(input logic we, input logic [AW-1:0] a,
                          input logic [LEN_W-1:0] l, output int acc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l; acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      vectors++; miscompares++;
      $display("FAIL req_accept: got no acceptance, required within 40 cycles");
    end
  endtask

  task automatic feed(input logic [DW-1:0] d [16], input int n,
                      input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          wdata_valid = 1'b0; wdata = 8'hEE;
          @(posedge clk); #1;
        end
      end
      wdata_valid = 1'b1; wdata = d[i];
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0; wdata = '0;
  endtask

  task automatic settle(output int idle_cyc);
    idle_cyc = -1;
    for (int k = 0; k < 60 && idle_cyc < 0; k++) begin
      @(negedge clk);
      if (!busy) idle_cyc = cyc;
    end
    if (idle_cyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL settle: busy still high, required low within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, busy, wdata_ready, rdata_valid, rdata_last, done, ram_wr_en} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 1000000",
               {req_ready, busy, wdata_ready, rdata_valid, rdata_last, done, ram_wr_en});
    end
    vectors++;
    if ({ram_addr, ram_din, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_buses: got addr=%h din=%h rdata=%h, required all zero", ram_addr, ram_din, rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst;
    logic [DW-1:0] d [16];
    int acc, idle, w0, d0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    d[0] = 8'h3F; d[1] = 8'hD4; d[2] = 8'hCD;
    w0 = wr_log.size(); d0 = done_log.size();
    send_req(1'b1, 12'h000, 4'd2, acc);
    feed(d, 3, -1, 0);
    settle(idle);
    vectors++;
    if (wr_log.size() - w0 != 3) begin
      miscompares++; $display("FAIL wr_count: got %0d writes, required 3", wr_log.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_log[w0+i] !== wr_t'{acc + 1 + i, AW'(i), d[i]}) begin
          miscompares++;
          $display("FAIL wr_beat%0d: got cyc=%0d a=%h d=%h, required cyc=%0d a=%h d=%h", i,
                   wr_log[w0+i].cyc, wr_log[w0+i].a, wr_log[w0+i].d, acc + 1 + i, i, d[i]);
        end
        ref_mem[i] = d[i];
      end
    end
    vectors++;
    if (done_log.size() - d0 != 1 || done_log[done_log.size()-1] != acc + 4) begin
      miscompares++; $display("FAIL wr_done: got %0d pulses, required 1 at cycle %0d", done_log.size() - d0, acc + 4);
    end
    vectors++;
    if (req_ready !== 1'b1 || ram_addr !== 12'h002 || ram_din !== 8'h00) begin
      miscompares++;
      $display("FAIL wr_idle: got ready=%b addr=%h din=%h, required 1 002 00", req_ready, ram_addr, ram_din);
    end
  endtask

  task automatic test_read_burst;
    int acc, idle, r0, d0;
    r0 = rd_log.size(); d0 = done_log.size();
    send_req(1'b0, 12'h000, 4'd2, acc);
    settle(idle);
    vectors++;
    if (rd_log.size() - r0 != 3) begin
      miscompares++; $display("FAIL rd_count: got %0d beats, required 3", rd_log.size() - r0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rd_log[r0+i] !== rd_t'{acc + 1 + RD_LAT + i, ref_mem[i], (i == 2)}) begin
          miscompares++;
          $display("FAIL rd_beat%0d: got cyc=%0d d=%h last=%b, required cyc=%0d d=%h last=%b", i,
                   rd_log[r0+i].cyc, rd_log[r0+i].d, rd_log[r0+i].last, acc + 1 + RD_LAT + i, ref_mem[i], i == 2);
        end
      end
    end
    vectors++;
    if (done_log.size() - d0 != 1 || done_log[done_log.size()-1] != acc + 1 + RD_LAT + 2) begin
      miscompares++; $display("FAIL rd_done: got %0d pulses, required 1 with the last beat", done_log.size() - d0);
    end
    vectors++;
    if (idle != acc + 3 + RD_LAT + 1) begin
      miscompares++; $display("FAIL rd_occupancy: got idle at %0d, required %0d", idle, acc + 3 + RD_LAT + 1);
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] d [16];
    int acc, idle, w0, r0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    d[0] = 8'h11; d[1] = 8'h22;
    w0 = wr_log.size();
    send_req(1'b1, 12'hFFF, 4'd1, acc);
    feed(d, 2, -1, 0);
    settle(idle);
    ref_mem[12'hFFF] = 8'h11; ref_mem[12'h000] = 8'h22;
    vectors++;
    if (wr_log.size() - w0 != 2 || wr_log[w0].a !== 12'hFFF || wr_log[w0+1].a !== 12'h000) begin
      miscompares++; $display("FAIL wrap_write: got %0d writes, required 2 at FFF then 000", wr_log.size() - w0);
    end
    r0 = rd_log.size();
    send_req(1'b0, 12'hFFF, 4'd1, acc);
    settle(idle);
    vectors++;
    if (rd_log.size() - r0 != 2 || rd_log[r0].d !== 8'h11 || rd_log[r0+1].d !== 8'h22 ||
        rd_log[r0].last !== 1'b0 || rd_log[r0+1].last !== 1'b1) begin
      miscompares++; $display("FAIL wrap_read: got %0d beats, required 11 then 22(last)", rd_log.size() - r0);
    end
  endtask

  task automatic test_stall;
    logic [DW-1:0] d [16];
    int acc, idle, w0, d0, ecyc;
    for (int i = 0; i < 16; i++) d[i] = DW'($urandom);
    w0 = wr_log.size(); d0 = done_log.size();
    send_req(1'b1, 12'h100, 4'd3, acc);
    feed(d, 4, 2, 2);
    settle(idle);
    vectors++;
    if (wr_log.size() - w0 != 4) begin
      miscompares++; $display("FAIL stall_count: got %0d writes, required 4", wr_log.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        ecyc = acc + 1 + i + ((i >= 2) ? 2 : 0);
        ref_mem[12'h100 + i] = d[i];
        vectors++;
        if (wr_log[w0+i] !== wr_t'{ecyc, 12'h100 + AW'(i), d[i]}) begin
          miscompares++;
          $display("FAIL stall_beat%0d: got cyc=%0d a=%h d=%h, required cyc=%0d a=%h d=%h", i,
                   wr_log[w0+i].cyc, wr_log[w0+i].a, wr_log[w0+i].d, ecyc, 12'h100 + i, d[i]);
        end
      end
    end
    vectors++;
    if (done_log.size() - d0 != 1 || done_log[done_log.size()-1] != acc + 7) begin
      miscompares++; $display("FAIL stall_done: got %0d pulses, required 1 at cycle %0d", done_log.size() - d0, acc + 7);
    end
  endtask

  task automatic test_busy_ignore;
    int acc1, acc2, a0, r0, idle, ready_seen;
    a0 = acc_log.size(); r0 = rd_log.size();
    send_req(1'b0, 12'h100, 4'd5, acc1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFF; req_len = 4'd1;
    acc2 = -1; ready_seen = 0;
    for (int k = 0; k < 40 && acc2 < 0; k++) begin
      @(negedge clk);
      if (req_ready) acc2 = cyc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    settle(idle);
    vectors++;
    if (acc2 != acc1 + 6 + RD_LAT + 1) begin
      miscompares++; $display("FAIL busy_accept: got second acceptance at %0d, required %0d", acc2, acc1 + 6 + RD_LAT + 1);
    end
    vectors++;
    if (acc_log.size() - a0 != 2) begin
      miscompares++; $display("FAIL busy_once: got %0d acceptances, required 2", acc_log.size() - a0);
    end
    vectors++;
    if (rd_log.size() - r0 != 8) begin
      miscompares++; $display("FAIL busy_beats: got %0d beats, required 8", rd_log.size() - r0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rd_log[r0+i].d !== ((i < 6) ? ref_mem[12'h100 + i] : ref_mem[wrap_add(12'hFFF, i - 6)]))
          ready_seen++;
      end
      vectors++;
      if (ready_seen != 0) begin
        miscompares++; $display("FAIL busy_data: got %0d wrong beats, required 0", ready_seen);
      end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] d [16];
    logic          we;
    logic [AW-1:0] a;
    logic [LEN_W-1:0] l;
    int acc, idle, w0, r0, d0, n, st_at, st_len, ecyc, last_cyc;
    for (int b = 0; b < 16; b++) begin
      we = 1'($urandom);
      a  = ($urandom % 2) ? AW'($urandom % 48) : AW'(4088 + ($urandom % 8));
      l  = LEN_W'($urandom);
      n  = int'(l) + 1;
      for (int i = 0; i < 16; i++) d[i] = DW'($urandom);
      st_at  = ($urandom % 2) ? int'($urandom % n) : -1;
      st_len = 1 + int'($urandom % 3);
      w0 = wr_log.size(); r0 = rd_log.size(); d0 = done_log.size();
      send_req(we, a, l, acc);
      if (we) feed(d, n, st_at, st_len);
      settle(idle);
      vectors++;
      if (we) begin
        if (wr_log.size() - w0 != n) begin
          miscompares++; $display("FAIL rnd%0d_wr_count: got %0d, required %0d", b, wr_log.size() - w0, n);
        end else begin
          last_cyc = 0;
          for (int i = 0; i < n; i++) begin
            ecyc = acc + 1 + i + ((st_at >= 0 && i >= st_at) ? st_len : 0);
            last_cyc = ecyc;
            ref_mem[wrap_add(a, i)] = d[i];
            vectors++;
            if (wr_log[w0+i] !== wr_t'{ecyc, wrap_add(a, i), d[i]}) begin
              miscompares++;
              $display("FAIL rnd%0d_wr%0d: got cyc=%0d a=%h d=%h, required cyc=%0d a=%h d=%h", b, i,
                       wr_log[w0+i].cyc, wr_log[w0+i].a, wr_log[w0+i].d, ecyc, wrap_add(a, i), d[i]);
            end
          end
          vectors++;
          if (done_log.size() - d0 != 1 || done_log[done_log.size()-1] != last_cyc + 1) begin
            miscompares++; $display("FAIL rnd%0d_wr_done: got %0d pulses, required 1 at %0d", b, done_log.size() - d0, last_cyc + 1);
          end
        end
      end else begin
        if (rd_log.size() - r0 != n) begin
          miscompares++; $display("FAIL rnd%0d_rd_count: got %0d, required %0d", b, rd_log.size() - r0, n);
        end else begin
          for (int i = 0; i < n; i++) begin
            ecyc = acc + 1 + RD_LAT + i;
            vectors++;
            if (rd_log[r0+i] !== rd_t'{ecyc, ref_mem[wrap_add(a, i)], (i == n - 1)}) begin
              miscompares++;
              $display("FAIL rnd%0d_rd%0d: got cyc=%0d d=%h last=%b, required cyc=%0d d=%h last=%b", b, i,
                       rd_log[r0+i].cyc, rd_log[r0+i].d, rd_log[r0+i].last, ecyc, ref_mem[wrap_add(a, i)], i == n - 1);
            end
          end
          vectors++;
          if (done_log.size() - d0 != 1 || done_log[done_log.size()-1] != acc + RD_LAT + n) begin
            miscompares++; $display("FAIL rnd%0d_rd_done: got %0d pulses, required 1 at %0d", b, done_log.size() - d0, acc + RD_LAT + n);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [DW-1:0] d [16];
    int acc, idle, w0, d0, r0;
    for (int i = 0; i < 16; i++) d[i] = DW'($urandom);
    w0 = wr_log.size(); d0 = done_log.size();
    send_req(1'b1, 12'h200, 4'd3, acc);
    feed(d, 2, -1, 0);
    wdata_valid = 1'b1; wdata = d[2]; rst = 1'b1;
    #1;
    vectors++;
    if (ram_wr_en !== 1'b0 || busy !== 1'b0 || wdata_ready !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_immediate: got wr_en=%b busy=%b wready=%b, required 0 0 0", ram_wr_en, busy, wdata_ready);
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, rdata_valid, rdata_last, done, ram_wr_en} !== 5'b10000 || {ram_addr, ram_din, rdata} !== '0) begin
      miscompares++; $display("FAIL rstmid_outputs: got ready=%b addr=%h din=%h done=%b, required reset values",
                              req_ready, ram_addr, ram_din, done);
    end
    @(posedge clk); #1;
    rst = 1'b0; wdata_valid = 1'b0; wdata = '0;
    repeat (5) @(posedge clk);
    #1;
    ref_mem[12'h200] = d[0]; ref_mem[12'h201] = d[1];
    vectors++;
    if (wr_log.size() - w0 != 2 || done_log.size() - d0 != 0) begin
      miscompares++; $display("FAIL rstmid_aborted: got %0d writes %0d done, required 2 writes 0 done",
                              wr_log.size() - w0, done_log.size() - d0);
    end
    r0 = rd_log.size();
    send_req(1'b0, 12'h200, 4'd3, acc);
    settle(idle);
    vectors++;
    if (rd_log.size() - r0 != 4 || rd_log[r0].d !== ref_mem[12'h200] || rd_log[r0+1].d !== ref_mem[12'h201] ||
        rd_log[r0+2].d !== ref_mem[12'h202] || rd_log[r0+3].d !== ref_mem[12'h203]) begin
      miscompares++; $display("FAIL rstmid_readback: got %0d beats or wrong data, required 4 matching", rd_log.size() - r0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset;
    test_write_burst;
    test_read_burst;
    test_wrap;
    test_stall;
    test_busy_ignore;
    test_random;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
